// File: rtl/e203_itcm_icb_arbt.sv
// e203_itcm_icb_arbt: shares the ITCM ICB slave port between the IFU fetch path and the ext2itcm path
// Ports:
//   clk, rst_n                 core clock, synchronous active-low reset
//   ifu_icb_cmd_* / rsp_*      IFU master side (cmd in, rsp out)
//   ext_icb_cmd_* / rsp_*      external master side (cmd in, rsp out)
//   itcm_icb_cmd_* / rsp_*     ITCM slave side (cmd out, rsp in)
//   arbt_orphan_err            sticky flag: ITCM response seen with nothing outstanding
// Build option: define E203_ITCM_ARBT_RR_EN for round-robin arbitration, otherwise ext has fixed priority over ifu.
module e203_itcm_icb_arbt #(
  parameter int AW = 16,
  parameter int OUTS_N = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_icb_cmd_valid,
  output logic          ifu_icb_cmd_ready,
  input  logic [AW-1:0] ifu_icb_cmd_addr,
  input  logic          ifu_icb_cmd_read,
  input  logic [31:0]   ifu_icb_cmd_wdata,
  input  logic [3:0]    ifu_icb_cmd_wmask,
  output logic          ifu_icb_rsp_valid,
  input  logic          ifu_icb_rsp_ready,
  output logic          ifu_icb_rsp_err,
  output logic [31:0]   ifu_icb_rsp_rdata,
  input  logic          ext_icb_cmd_valid,
  output logic          ext_icb_cmd_ready,
  input  logic [AW-1:0] ext_icb_cmd_addr,
  input  logic          ext_icb_cmd_read,
  input  logic [31:0]   ext_icb_cmd_wdata,
  input  logic [3:0]    ext_icb_cmd_wmask,
  output logic          ext_icb_rsp_valid,
  input  logic          ext_icb_rsp_ready,
  output logic          ext_icb_rsp_err,
  output logic [31:0]   ext_icb_rsp_rdata,
  output logic          itcm_icb_cmd_valid,
  input  logic          itcm_icb_cmd_ready,
  output logic [AW-1:0] itcm_icb_cmd_addr,
  output logic          itcm_icb_cmd_read,
  output logic [31:0]   itcm_icb_cmd_wdata,
  output logic [3:0]    itcm_icb_cmd_wmask,
  input  logic          itcm_icb_rsp_valid,
  output logic          itcm_icb_rsp_ready,
  input  logic          itcm_icb_rsp_err,
  input  logic [31:0]   itcm_icb_rsp_rdata,
  output logic          arbt_orphan_err
);
  localparam int PW = OUTS_N > 1 ? $clog2(OUTS_N) : 1;
  localparam int CW = $clog2(OUTS_N + 1);
  logic [CW-1:0] cnt;
  logic [PW-1:0] wptr, rptr;
  logic [OUTS_N-1:0] ids;
  logic lock, lock_ext, orphan, full, empty, pick_ext, sel_ext, cmd_hs, rsp_hs, head_ext;
  assign full = cnt == CW'(OUTS_N);
  assign empty = cnt == '0;
`ifdef E203_ITCM_ARBT_RR_EN
  logic rr_last;
  // on contention, the master that did not win last time goes first
  assign pick_ext = ext_icb_cmd_valid & (!ifu_icb_cmd_valid | !rr_last);
  always_ff @(posedge clk)
    if (!rst_n) rr_last <= 1'b0;
    else if (cmd_hs) rr_last <= sel_ext;
`else
  assign pick_ext = ext_icb_cmd_valid;
`endif
  // a stalled command keeps its grant so the payload seen by ITCM stays stable
  assign sel_ext = lock ? lock_ext : pick_ext;
  assign itcm_icb_cmd_valid = (sel_ext ? ext_icb_cmd_valid : ifu_icb_cmd_valid) & !full;
  assign itcm_icb_cmd_addr = sel_ext ? ext_icb_cmd_addr : ifu_icb_cmd_addr;
  assign itcm_icb_cmd_read = sel_ext ? ext_icb_cmd_read : ifu_icb_cmd_read;
  assign itcm_icb_cmd_wdata = sel_ext ? ext_icb_cmd_wdata : ifu_icb_cmd_wdata;
  assign itcm_icb_cmd_wmask = sel_ext ? ext_icb_cmd_wmask : ifu_icb_cmd_wmask;
  assign ifu_icb_cmd_ready = !sel_ext & itcm_icb_cmd_ready & !full;
  assign ext_icb_cmd_ready = sel_ext & itcm_icb_cmd_ready & !full;
  assign cmd_hs = itcm_icb_cmd_valid & itcm_icb_cmd_ready;
  assign head_ext = ids[rptr];
  assign ifu_icb_rsp_valid = itcm_icb_rsp_valid & !empty & !head_ext;
  assign ext_icb_rsp_valid = itcm_icb_rsp_valid & !empty & head_ext;
  assign ifu_icb_rsp_err = itcm_icb_rsp_err;
  assign ext_icb_rsp_err = itcm_icb_rsp_err;
  assign ifu_icb_rsp_rdata = itcm_icb_rsp_rdata;
  assign ext_icb_rsp_rdata = itcm_icb_rsp_rdata;
  // with nothing outstanding, responses are drained so ITCM cannot hang
  assign itcm_icb_rsp_ready = empty | (head_ext ? ext_icb_rsp_ready : ifu_icb_rsp_ready);
  assign rsp_hs = itcm_icb_rsp_valid & itcm_icb_rsp_ready & !empty;
  assign arbt_orphan_err = orphan;
  always_ff @(posedge clk)
    if (!rst_n) begin
      cnt <= '0;
      wptr <= '0;
      rptr <= '0;
      lock <= 1'b0;
      lock_ext <= 1'b0;
      orphan <= 1'b0;
    end else begin
      lock <= itcm_icb_cmd_valid & !itcm_icb_cmd_ready;
      lock_ext <= sel_ext;
      orphan <= orphan | (itcm_icb_rsp_valid & empty);
      cnt <= cnt + CW'(cmd_hs) - CW'(rsp_hs);
      if (cmd_hs) begin
        ids[wptr] <= sel_ext;
        wptr <= (wptr == PW'(OUTS_N - 1)) ? '0 : wptr + 1'b1;
      end
      if (rsp_hs) rptr <= (rptr == PW'(OUTS_N - 1)) ? '0 : rptr + 1'b1;
    end
endmodule
